// File: rtl/neuron_if.sv
// Stream bundle between the neuron, the previous layer (arg/err) and the sigmoid (res/fbk).
// The neuron sits on the slave modport; the surrounding logic drives the master side.
interface neuron_if #(
  parameter int unsigned ARG_DEPTH = 4,
  parameter int unsigned ARG_WIDTH = 8,
  parameter int unsigned RES_WIDTH = 16,
  parameter int unsigned FBK_WIDTH = 16
);
  logic                           en;
  logic [ARG_DEPTH*ARG_WIDTH-1:0] arg_data;
  logic                           arg_valid;
  logic                           arg_ready;
  logic [RES_WIDTH-1:0]           res_data;
  logic                           res_valid;
  logic                           res_ready;
  logic [FBK_WIDTH-1:0]           fbk_data;
  logic                           fbk_valid;
  logic                           fbk_ready;
  logic [ARG_DEPTH*FBK_WIDTH-1:0] err_data;
  logic                           err_valid;
  logic                           err_ready;

  modport slave (
    input  en, arg_data, arg_valid, res_ready, fbk_data, fbk_valid, err_ready,
    output arg_ready, res_data, res_valid, fbk_ready, err_data, err_valid
  );

  modport master (
    output en, arg_data, arg_valid, res_ready, fbk_data, fbk_valid, err_ready,
    input  arg_ready, res_data, res_valid, fbk_ready, err_data, err_valid
  );
endinterface

// File: rtl/neuron.sv
// Weighted-sum neuron: serial MAC forward pass into the sigmoid, optional weight training.
// Define NEURON_BIAS_EN to add a trainable bias register (otherwise bias is constant zero).
module neuron #(
  parameter int unsigned ARG_DEPTH   = 4,
  parameter int unsigned ARG_WIDTH   = 8,
  parameter int unsigned RES_WIDTH   = 16,
  parameter int unsigned FBK_WIDTH   = 16,
  parameter logic [15:0] WEIGHT_INIT = 16'h0100,
  parameter int unsigned RATE_SHIFT  = 4
) (
  input logic     clk,
  input logic     rst_n,
  neuron_if.slave bus
);
  localparam int unsigned AccW = 32;
  localparam int unsigned Frac = 8;
  localparam int unsigned CntW = $clog2(ARG_DEPTH + 1);
  localparam int unsigned IdxW = (ARG_DEPTH > 1) ? $clog2(ARG_DEPTH) : 1;
  localparam int          SatHi = (1 << (RES_WIDTH - 1)) - 1;
  localparam int          SatLo = -SatHi - 1;
  localparam logic [CntW-1:0] LastMac = CntW'(ARG_DEPTH - 1);
`ifdef NEURON_BIAS_EN
  localparam logic [CntW-1:0] LastUpd = CntW'(ARG_DEPTH);
`else
  localparam logic [CntW-1:0] LastUpd = CntW'(ARG_DEPTH - 1);
`endif

  typedef enum logic [2:0] {StIdle, StMac, StFwd, StWaitFbk, StUpdate, StBwd} state_e;

  function automatic logic [RES_WIDTH-1:0] sat(input logic signed [AccW-1:0] v);
    if (v > SatHi) return RES_WIDTH'(SatHi);
    if (v < SatLo) return RES_WIDTH'(SatLo);
    return v[RES_WIDTH-1:0];
  endfunction

  function automatic logic signed [AccW-1:0] sx(input logic [RES_WIDTH-1:0] v);
    return {{(AccW-RES_WIDTH){v[RES_WIDTH-1]}}, v};
  endfunction

  state_e                         state_q, state_d;
  logic [CntW-1:0]                idx_q, idx_d;
  logic signed [AccW-1:0]         acc_q, acc_d;
  logic [ARG_DEPTH*ARG_WIDTH-1:0] x_q, x_d;
  logic                           en_q, en_d;
  logic [FBK_WIDTH-1:0]           d_q, d_d;
  logic [RES_WIDTH-1:0]           w_q [ARG_DEPTH];
  logic [RES_WIDTH-1:0]           w_d [ARG_DEPTH];
  logic [FBK_WIDTH-1:0]           err_q [ARG_DEPTH];
  logic [FBK_WIDTH-1:0]           err_d [ARG_DEPTH];
  logic [RES_WIDTH-1:0]           res_data_q, res_data_d;
  logic                           res_valid_q, res_valid_d;
  logic                           err_valid_q, err_valid_d;
  logic [RES_WIDTH-1:0]           bias;
`ifdef NEURON_BIAS_EN
  logic [RES_WIDTH-1:0]           bias_q, bias_d;
  assign bias = bias_q;
`else
  assign bias = '0;
`endif

  logic [IdxW-1:0]        eidx;
  logic [ARG_WIDTH-1:0]   x_cur;
  logic signed [AccW-1:0] x_s, w_s, d_s, prod, dw, dx;

  assign eidx  = idx_q[IdxW-1:0];
  assign x_cur = x_q[eidx*ARG_WIDTH +: ARG_WIDTH];
  assign x_s   = $signed({{(AccW-ARG_WIDTH){1'b0}}, x_cur});
  assign w_s   = sx(w_q[eidx]);
  assign d_s   = sx(d_q);
  assign prod  = x_s * w_s;
  assign dw    = d_s * w_s;
  assign dx    = d_s * x_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (bus.arg_valid) state_d = StMac;
      StMac:     if (idx_q == LastMac) state_d = StFwd;
      StFwd:     if (res_valid_q && bus.res_ready) state_d = en_q ? StWaitFbk : StIdle;
      StWaitFbk: if (bus.fbk_valid) state_d = StUpdate;
      StUpdate:  if (idx_q == LastUpd) state_d = StBwd;
      StBwd:     if (err_valid_q && bus.err_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.arg_ready = (state_q == StIdle);
    bus.fbk_ready = (state_q == StWaitFbk);
    bus.res_data  = res_data_q;
    bus.res_valid = res_valid_q;
    bus.err_valid = err_valid_q;
    bus.err_data  = '0;
    for (int i = 0; i < ARG_DEPTH; i++) bus.err_data[i*FBK_WIDTH +: FBK_WIDTH] = err_q[i];
  end

  always_comb begin
    idx_d       = idx_q;
    acc_d       = acc_q;
    x_d         = x_q;
    en_d        = en_q;
    d_d         = d_q;
    w_d         = w_q;
    err_d       = err_q;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    err_valid_d = err_valid_q;
`ifdef NEURON_BIAS_EN
    bias_d      = bias_q;
`endif
    unique case (state_q)
      StIdle: if (bus.arg_valid) begin
        x_d   = bus.arg_data;
        en_d  = bus.en;
        acc_d = sx(bias) <<< Frac;
        idx_d = '0;
      end
      StMac: begin
        acc_d = acc_q + prod;
        idx_d = (idx_q == LastMac) ? '0 : idx_q + 1'b1;
      end
      // First FWD cycle registers the result; valid then holds until taken.
      StFwd: begin
        if (!res_valid_q) begin
          res_valid_d = 1'b1;
          res_data_d  = sat(acc_q >>> Frac);
        end else if (bus.res_ready) begin
          res_valid_d = 1'b0;
        end
      end
      StWaitFbk: if (bus.fbk_valid) begin
        d_d   = bus.fbk_data;
        idx_d = '0;
      end
      StUpdate: begin
        idx_d = idx_q + 1'b1;
        if (idx_q < CntW'(ARG_DEPTH)) begin
          err_d[eidx] = sat(dw >>> Frac);
          w_d[eidx]   = sat(w_s - (dx >>> (Frac + RATE_SHIFT)));
        end
`ifdef NEURON_BIAS_EN
        else begin
          bias_d = sat(sx(bias_q) - (d_s >>> RATE_SHIFT));
        end
`endif
      end
      StBwd: begin
        if (!err_valid_q) err_valid_d = 1'b1;
        else if (bus.err_ready) err_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q       <= '0;
      acc_q       <= '0;
      x_q         <= '0;
      en_q        <= 1'b0;
      d_q         <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      err_valid_q <= 1'b0;
      for (int i = 0; i < ARG_DEPTH; i++) begin
        w_q[i]   <= WEIGHT_INIT;
        err_q[i] <= '0;
      end
`ifdef NEURON_BIAS_EN
      bias_q      <= '0;
`endif
    end else begin
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      x_q         <= x_d;
      en_q        <= en_d;
      d_q         <= d_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      err_valid_q <= err_valid_d;
      w_q         <= w_d;
      err_q       <= err_d;
`ifdef NEURON_BIAS_EN
      bias_q      <= bias_d;
`endif
    end
  end
endmodule

// File: tb/tb_neuron.sv
// Directed bench for neuron: forward passes, backpressure, one training step, mid-MAC reset.
// Expected values follow the NEURON_BIAS_EN setting of the build.
module tb_neuron;
`ifdef NEURON_BIAS_EN
  localparam int          ErrLat  = 6;
  localparam logic [15:0] Retrain = 16'h01e0;
`else
  localparam int          ErrLat  = 5;
  localparam logic [15:0] Retrain = 16'h01f0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  neuron_if #(.ARG_DEPTH(4), .ARG_WIDTH(8), .RES_WIDTH(16), .FBK_WIDTH(16)) bus ();

  neuron #(
    .ARG_DEPTH(4), .ARG_WIDTH(8), .RES_WIDTH(16), .FBK_WIDTH(16),
    .WEIGHT_INIT(16'h0100), .RATE_SHIFT(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_arg(input logic [7:0] x, input logic e);
    bus.arg_data  = {4{x}};
    bus.en        = e;
    bus.arg_valid = 1'b1;
    tick();
    bus.arg_valid = 1'b0;
  endtask

  task automatic wait_res(output int lat);
    int k = 0;
    lat = -1;
    while (lat < 0 && k < 30) begin
      tick();
      k++;
      if (bus.res_valid === 1'b1) lat = k;
    end
  endtask

  task automatic wait_err(output int lat);
    int k = 0;
    lat = -1;
    while (lat < 0 && k < 30) begin
      tick();
      k++;
      if (bus.err_valid === 1'b1) lat = k;
    end
  endtask

  task automatic take_res();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
  endtask

  task automatic take_err();
    bus.err_ready = 1'b1;
    tick();
    bus.err_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.en        = 1'b0;
    bus.arg_data  = '0;
    bus.arg_valid = 1'b0;
    bus.res_ready = 1'b0;
    bus.fbk_data  = '0;
    bus.fbk_valid = 1'b0;
    bus.err_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (bus.arg_ready !== 1'b1) begin n_err++; $display("FAIL reset_arg_ready: got %b want 1", bus.arg_ready); end
    n_vec++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid); end
    n_vec++; if (bus.fbk_ready !== 1'b0) begin n_err++; $display("FAIL reset_fbk_ready: got %b want 0", bus.fbk_ready); end
    n_vec++; if (bus.err_valid !== 1'b0) begin n_err++; $display("FAIL reset_err_valid: got %b want 0", bus.err_valid); end
    n_vec++; if (bus.res_data !== 16'h0000) begin n_err++; $display("FAIL reset_res_data: got %h want 0000", bus.res_data); end
    n_vec++; if (bus.err_data !== 64'h0) begin n_err++; $display("FAIL reset_err_data: got %h want 0", bus.err_data); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_forward();
    int lat;
    send_arg(8'h80, 1'b0);
    wait_res(lat);
    n_vec++; if (lat !== 5) begin n_err++; $display("FAIL fwd_latency: got %0d want 5", lat); end
    n_vec++; if (bus.res_data !== 16'h0200) begin n_err++; $display("FAIL fwd_half: got %h want 0200", bus.res_data); end
    take_res();
    n_vec++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL fwd_valid_drop: got %b want 0", bus.res_valid); end
    n_vec++; if (bus.arg_ready !== 1'b1) begin n_err++; $display("FAIL fwd_idle_ready: got %b want 1", bus.arg_ready); end
    n_vec++; if (bus.fbk_ready !== 1'b0) begin n_err++; $display("FAIL fwd_no_fbk: got %b want 0", bus.fbk_ready); end
  endtask

  task automatic test_forward_max();
    int lat;
    send_arg(8'hff, 1'b0);
    wait_res(lat);
    n_vec++; if (lat !== 5) begin n_err++; $display("FAIL max_latency: got %0d want 5", lat); end
    n_vec++; if (bus.res_data !== 16'h03fc) begin n_err++; $display("FAIL max_sum: got %h want 03fc", bus.res_data); end
    take_res();
  endtask

  task automatic test_backpressure();
    int lat;
    send_arg(8'hff, 1'b0);
    wait_res(lat);
    n_vec++; if (lat !== 5) begin n_err++; $display("FAIL bp_latency: got %0d want 5", lat); end
    for (int c = 0; c < 3; c++) begin
      n_vec++; if (bus.res_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid_hold[%0d]: got %b want 1", c, bus.res_valid); end
      n_vec++; if (bus.res_data !== 16'h03fc) begin n_err++; $display("FAIL bp_data_hold[%0d]: got %h want 03fc", c, bus.res_data); end
      n_vec++; if (bus.arg_ready !== 1'b0) begin n_err++; $display("FAIL bp_arg_ready[%0d]: got %b want 0", c, bus.arg_ready); end
      n_vec++; if (bus.fbk_ready !== 1'b0) begin n_err++; $display("FAIL bp_fbk_ready[%0d]: got %b want 0", c, bus.fbk_ready); end
      tick();
    end
    take_res();
    n_vec++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL bp_handshake: got %b want 0", bus.res_valid); end
    n_vec++; if (bus.arg_ready !== 1'b1) begin n_err++; $display("FAIL bp_idle: got %b want 1", bus.arg_ready); end
  endtask

  task automatic test_train();
    int lat;
    send_arg(8'h80, 1'b1);
    bus.en        = 1'b0;  // must not affect the accepted transaction
    bus.fbk_data  = 16'h7777;
    bus.fbk_valid = 1'b1;
    n_vec++; if (bus.fbk_ready !== 1'b0) begin n_err++; $display("FAIL train_fbk_ignored: got %b want 0", bus.fbk_ready); end
    wait_res(lat);
    n_vec++; if (bus.res_data !== 16'h0200) begin n_err++; $display("FAIL train_fwd: got %h want 0200", bus.res_data); end
    bus.fbk_valid = 1'b0;
    take_res();
    n_vec++; if (bus.fbk_ready !== 1'b1) begin n_err++; $display("FAIL train_wait_fbk: got %b want 1", bus.fbk_ready); end
    n_vec++; if (bus.arg_ready !== 1'b0) begin n_err++; $display("FAIL train_arg_blocked: got %b want 0", bus.arg_ready); end
    bus.fbk_data  = 16'h0100;
    bus.fbk_valid = 1'b1;
    tick();
    bus.fbk_valid = 1'b0;
    wait_err(lat);
    n_vec++; if (lat !== ErrLat) begin n_err++; $display("FAIL err_latency: got %0d want %0d", lat, ErrLat); end
    n_vec++; if (bus.err_data !== {4{16'h0100}}) begin n_err++; $display("FAIL err_data: got %h want %h", bus.err_data, {4{16'h0100}}); end
    tick();
    n_vec++; if (bus.err_valid !== 1'b1) begin n_err++; $display("FAIL err_valid_hold: got %b want 1", bus.err_valid); end
    n_vec++; if (bus.err_data !== {4{16'h0100}}) begin n_err++; $display("FAIL err_data_hold: got %h want %h", bus.err_data, {4{16'h0100}}); end
    n_vec++; if (bus.arg_ready !== 1'b0) begin n_err++; $display("FAIL err_arg_blocked: got %b want 0", bus.arg_ready); end
    take_err();
    n_vec++; if (bus.err_valid !== 1'b0) begin n_err++; $display("FAIL err_handshake: got %b want 0", bus.err_valid); end
    n_vec++; if (bus.arg_ready !== 1'b1) begin n_err++; $display("FAIL err_idle: got %b want 1", bus.arg_ready); end
    send_arg(8'h80, 1'b0);
    wait_res(lat);
    n_vec++; if (bus.res_data !== Retrain) begin n_err++; $display("FAIL retrain_fwd: got %h want %h", bus.res_data, Retrain); end
    take_res();
  endtask

  task automatic test_reset_mid();
    int lat;
    send_arg(8'h80, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    n_vec++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL midrst_res_valid: got %b want 0", bus.res_valid); end
    n_vec++; if (bus.arg_ready !== 1'b1) begin n_err++; $display("FAIL midrst_arg_ready: got %b want 1", bus.arg_ready); end
    tick();
    rst_n = 1'b1;
    tick();
    n_vec++; if (bus.arg_ready !== 1'b1) begin n_err++; $display("FAIL midrst_release: got %b want 1", bus.arg_ready); end
    send_arg(8'h80, 1'b0);
    wait_res(lat);
    n_vec++; if (lat !== 5) begin n_err++; $display("FAIL midrst_latency: got %0d want 5", lat); end
    n_vec++; if (bus.res_data !== 16'h0200) begin n_err++; $display("FAIL midrst_weights: got %h want 0200", bus.res_data); end
    take_res();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_forward_max();
    test_backpressure();
    test_train();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timed out");
  end
endmodule

// File: doc/neuron.md
# neuron

Weighted-sum stage that sits directly upstream of the sigmoid activation unit. Accepts a vector of unsigned 8-bit activations from the previous layer and computes a saturated Q8.8 weighted sum plus bias, one multiply-accumulate per cycle. The sum is presented to the sigmoid as its 16-bit argument. When training is enabled, it consumes the sigmoid's 16-bit feedback (delta), updates its weights and emits a per-input error vector to the previous layer.

## Interface
- `ARG_DEPTH`, 4: number of inputs/weights.
- `ARG_WIDTH`, 8: input width, unsigned Q0.8.
- `RES_WIDTH`, 16: sum width, signed Q8.8.
- `FBK_WIDTH`, 16: delta/error width, signed Q8.8.
- `WEIGHT_INIT`, 16'h0100: reset value of every weight (1.0).
- `RATE_SHIFT`, 4: learning rate as 2^-RATE_SHIFT.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `en`  in  1  training enable; sampled on arg accept.
- `arg_data`  in  ARG_DEPTH*ARG_WIDTH  inputs; element i at [i*ARG_WIDTH +: ARG_WIDTH].
- `arg_valid`  in  1.
- `arg_ready`  out  1.
- `res_data`  out  RES_WIDTH  weighted sum to the sigmoid.
- `res_valid`  out  1.
- `res_ready`  in  1.
- `fbk_data`  in  FBK_WIDTH  delta from the sigmoid.
- `fbk_valid`  in  1.
- `fbk_ready`  out  1.
- `err_data`  out  ARG_DEPTH*FBK_WIDTH  per-input error to the previous layer.
- `err_valid`  out  1.
- `err_ready`  in  1.

## Operation
- States: IDLE, MAC, FWD, WAIT_FBK, UPDATE, BWD.
- IDLE: `arg_ready`=1. On `arg_valid`&`arg_ready`: latch `arg_data` and `en`. Load the accumulator with bias<<8, then go to MAC.
- MAC: for i=0..ARG_DEPTH-1, one per cycle: acc += x[i]*w[i]. The product is unsigned 8 × signed 16, giving signed Q8.16. The accumulator is 32-bit signed. After the last product, go to FWD.
- FWD: `res_data` = sat16(acc>>>8). sat16 clamps to [16'h8000, 16'h7fff]. `res_valid`=1. On handshake: go to WAIT_FBK if latched en, else IDLE.
- WAIT_FBK: `fbk_ready`=1. On handshake, latch delta d and go to UPDATE.
- UPDATE: for i=0..ARG_DEPTH-1, one per cycle, using the old w[i]:
  - err[i] = sat16((d*w[i])>>>8).
  - w[i] = sat16(w[i] − ((d*x[i])>>>(8+RATE_SHIFT))).
- After the last element: bias = sat16(bias − (d>>>RATE_SHIFT)), then go to BWD.
- BWD: `err_valid`=1. On handshake, go to IDLE.
- All shifts are arithmetic (floor). All saturation is applied before the register write.

## Timing
- Reset (asynchronous, `rst_n` low):
  - State IDLE; `arg_ready`=1; all other ready/valid outputs 0.
  - `res_data` and `err_data` 0.
  - All weights `WEIGHT_INIT`; bias 0.
  - Reset mid-operation aborts the transaction and restores the initial weights.
- Latency: `res_valid` rises ARG_DEPTH+1 cycles after the arg accept edge.
- Error latency: `err_valid` rises ARG_DEPTH+2 cycles after the fbk accept edge.
- Outputs are registered. `res_data`/`err_data` hold stable while valid is high and ready is low.
- Valid never drops without a handshake.
- `arg_ready` is 0 in every state except IDLE. A new arg can be accepted the cycle after the `res` handshake (en=0) or the `err` handshake.
- `fbk_valid` outside WAIT_FBK is ignored (`fbk_ready`=0).
- Changes to `en` after accept have no effect on the current transaction.

## Configuration
- `NEURON_BIAS_EN` defined: bias register present, added in MAC and updated in UPDATE (UPDATE takes ARG_DEPTH+1 cycles).
- `NEURON_BIAS_EN` undefined: bias is constant 0, there is no bias update, and UPDATE takes ARG_DEPTH cycles (error latency ARG_DEPTH+1).

## Test plan
- Reset, en=0, arg = 4×8'h80: `res_data`=16'h0200, valid 5 cycles after accept; `arg_ready`=1, returns to IDLE.
- en=0, arg = 4×8'hff: `res_data`=16'h03fc.
- `res_ready` held low 3 cycles while `res_valid`: `res_data` stable, `arg_ready`=0, `fbk_ready`=0. Handshake completes on the first ready cycle.
- Training, with bias enabled:
  - en=1, arg = 4×8'h80 gives res 16'h0200.
  - fbk 16'h0100 gives `err_data` = 4×16'h0100.
  - Weights become 16'h00f8 and bias becomes 16'hfff0.
  - The next forward pass with the same arg gives 16'h01e0 (16'h01f0 without `NEURON_BIAS_EN`).
- Reset asserted during MAC (cycle 2 after accept): `res_valid`=0 immediately, `arg_ready`=1 after release. A forward pass with 4×8'h80 again gives 16'h0200 (weights restored).
